// File: rtl/sec_pkg.sv
// rtl/sec_pkg.sv - mode encodings and helpers shared by the security zone controller
package sec_pkg;

  typedef enum logic [2:0] {
    MODE_DISARMED = 3'd0,
    MODE_EXIT     = 3'd1,
    MODE_ARMED    = 3'd2,
    MODE_ENTRY    = 3'd3,
    MODE_ALARM    = 3'd4,
    MODE_LOCKOUT  = 3'd5
  } sec_mode_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sec_delay_timer.sv
// rtl/sec_delay_timer.sv - loadable down-counter shared by exit, entry and lockout delays
module sec_delay_timer #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic [W-1:0] value_o,
  output logic         zero_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != '0) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign value_o = count_q;
  assign zero_o  = (count_q == '0);

endmodule

// File: rtl/security_zone_controller.sv
// rtl/security_zone_controller.sv - arm/entry/alarm FSM with PIN disarm and lockout
// Optional zone bypass input enabled by defining SEC_ZONE_BYPASS_EN.
module security_zone_controller
  import sec_pkg::*;
#(
  parameter int                NUM_ZONES      = 5,
  parameter int                PIN_W          = 4,
  parameter logic [PIN_W-1:0]  DISARM_PIN     = 4'h0,
  parameter int                EXIT_CYCLES    = 16,
  parameter int                ENTRY_CYCLES   = 8,
  parameter int                MAX_ATTEMPTS   = 3,
  parameter int                LOCKOUT_CYCLES = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              arm_req,
  input  logic [NUM_ZONES-1:0]              motion,
  input  logic [PIN_W-1:0]                  pin,
  input  logic                              pin_valid,
`ifdef SEC_ZONE_BYPASS_EN
  input  logic [NUM_ZONES-1:0]              bypass_mask,
`endif
  output logic [2:0]                        mode,
  output logic                              alarm,
  output logic [NUM_ZONES-1:0]              trig_zones,
  output logic                              pin_ok,
  output logic                              pin_err,
  output logic [$clog2(MAX_ATTEMPTS+1)-1:0] fail_cnt
);

  localparam int TW = $clog2(max3(EXIT_CYCLES, ENTRY_CYCLES, LOCKOUT_CYCLES) + 1);
  localparam int FW = $clog2(MAX_ATTEMPTS + 1);

  sec_mode_e            state_q, state_d;
  logic [NUM_ZONES-1:0] trig_q, trig_d;
  logic [FW-1:0]        fail_q, fail_d;
  logic                 ok_q, ok_d, err_q, err_d, alarm_q;
  logic                 tmr_load;
  logic [TW-1:0]        tmr_load_val;
  logic [TW-1:0]        tmr_value;
  logic                 tmr_zero;
  logic [NUM_ZONES-1:0] zones;
  logic                 pin_active;

`ifdef SEC_ZONE_BYPASS_EN
  assign zones = motion & ~bypass_mask;
`else
  assign zones = motion;
`endif

  sec_delay_timer #(.W(TW)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_load_val),
    .value_o    (tmr_value),
    .zero_o     (tmr_zero)
  );

  assign pin_active = (state_q == MODE_EXIT) || (state_q == MODE_ARMED) ||
                      (state_q == MODE_ENTRY) || (state_q == MODE_ALARM);

  always_comb begin
    state_d      = state_q;
    trig_d       = trig_q;
    fail_d       = fail_q;
    ok_d         = 1'b0;
    err_d        = 1'b0;
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    // A PIN entry outranks timer expiry and motion in the same cycle
    if (pin_active && pin_valid) begin
      if (pin == DISARM_PIN) begin
        state_d = MODE_DISARMED;
        ok_d    = 1'b1;
        fail_d  = '0;
      end else begin
        err_d = 1'b1;
        if (int'(fail_q) + 1 >= MAX_ATTEMPTS) begin
          fail_d       = FW'(MAX_ATTEMPTS);
          state_d      = MODE_LOCKOUT;
          tmr_load     = 1'b1;
          tmr_load_val = TW'(LOCKOUT_CYCLES - 1);
        end else begin
          fail_d = fail_q + FW'(1);
        end
      end
    end else begin
      case (state_q)
        MODE_DISARMED: begin
          if (arm_req) begin
            state_d      = MODE_EXIT;
            trig_d       = '0;
            tmr_load     = 1'b1;
            tmr_load_val = TW'(EXIT_CYCLES - 1);
          end
        end
        MODE_EXIT: begin
          if (tmr_zero) state_d = MODE_ARMED;
        end
        MODE_ARMED: begin
          if (|zones) begin
            state_d      = MODE_ENTRY;
            trig_d       = trig_q | zones;
            tmr_load     = 1'b1;
            tmr_load_val = TW'(ENTRY_CYCLES - 1);
          end
        end
        MODE_ENTRY: begin
          trig_d = trig_q | zones;
          if (tmr_zero) state_d = MODE_ALARM;
        end
        MODE_ALARM: begin
          trig_d = trig_q | zones;
        end
        MODE_LOCKOUT: begin
          if (tmr_zero) begin
            state_d = MODE_ALARM;
            fail_d  = '0;
          end
        end
        default: state_d = MODE_DISARMED;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MODE_DISARMED;
      trig_q  <= '0;
      fail_q  <= '0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
      alarm_q <= 1'b0;
    end else begin
      state_q <= state_d;
      trig_q  <= trig_d;
      fail_q  <= fail_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
      alarm_q <= (state_d == MODE_ALARM) || (state_d == MODE_LOCKOUT);
    end
  end

  assign mode       = state_q;
  assign alarm      = alarm_q;
  assign trig_zones = trig_q;
  assign pin_ok     = ok_q;
  assign pin_err    = err_q;
  assign fail_cnt   = fail_q;

  logic unused_tmr;
  assign unused_tmr = ^tmr_value;

endmodule

// File: tb/tb_security_zone_controller.sv
// tb/tb_security_zone_controller.sv - directed scoreboard bench for security_zone_controller
module tb_security_zone_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       arm_req = 1'b0;
  logic [4:0] motion = '0;
  logic [3:0] pin = '0;
  logic       pin_valid = 1'b0;
`ifdef SEC_ZONE_BYPASS_EN
  logic [4:0] bypass_mask = '0;
`endif
  logic [2:0] mode;
  logic       alarm;
  logic [4:0] trig_zones;
  logic       pin_ok;
  logic       pin_err;
  logic [1:0] fail_cnt;

  always #5 clk = ~clk;

  security_zone_controller dut (
    .clk        (clk),
    .rst        (rst),
    .arm_req    (arm_req),
    .motion     (motion),
    .pin        (pin),
    .pin_valid  (pin_valid),
`ifdef SEC_ZONE_BYPASS_EN
    .bypass_mask(bypass_mask),
`endif
    .mode       (mode),
    .alarm      (alarm),
    .trig_zones (trig_zones),
    .pin_ok     (pin_ok),
    .pin_err    (pin_err),
    .fail_cnt   (fail_cnt)
  );

  typedef struct {
    int         cyc;
    logic [2:0] mode;
    logic       alarm;
    logic [4:0] trig;
    logic       ok;
    logic       err;
    logic [1:0] fail;
    string      nm;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string nm, input string f, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s.%s got=%0d want=%0d (cycle %0d)", nm, f, got, want, cyc);
    end
  endtask

  // Monitor: samples 2 time units after each rising edge and retires matching expectations
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      cyc++;
      #2;
      while (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front();
        if (e.cyc < cyc) begin
          chk(e.nm, "missed", cyc, e.cyc);
        end else begin
          chk(e.nm, "mode",  int'(mode),       int'(e.mode));
          chk(e.nm, "alarm", int'(alarm),      int'(e.alarm));
          chk(e.nm, "trig",  int'(trig_zones), int'(e.trig));
          chk(e.nm, "ok",    int'(pin_ok),     int'(e.ok));
          chk(e.nm, "err",   int'(pin_err),    int'(e.err));
          chk(e.nm, "fail",  int'(fail_cnt),   int'(e.fail));
        end
      end
    end
  end

  task automatic step(input logic r, input logic a, input logic [4:0] m,
                      input logic [3:0] p, input logic pv,
                      input logic [2:0] em, input logic ea, input logic [4:0] et,
                      input logic eok, input logic eerr, input logic [1:0] ef,
                      input string nm);
    exp_t e;
    @(negedge clk);
    rst = r; arm_req = a; motion = m; pin = p; pin_valid = pv;
    e.cyc = cyc + 1; e.mode = em; e.alarm = ea; e.trig = et;
    e.ok = eok; e.err = eerr; e.fail = ef; e.nm = nm;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n, input logic [2:0] em, input logic ea,
                      input logic [4:0] et, input logic [1:0] ef, input string nm);
    for (int i = 0; i < n; i++) step(0, 0, 5'b0, 4'h0, 0, em, ea, et, 0, 0, ef, nm);
  endtask

  // Arm from DISARMED: 16 samples in EXIT, then ARMED with trig cleared
  task automatic arm_seq(input string nm);
    step(0, 1, 5'b0, 4'h0, 0, 3'd1, 0, 5'b0, 0, 0, 2'd0, {nm, "_arm"});
    idle(15, 3'd1, 0, 5'b0, 2'd0, {nm, "_exit"});
    idle(1, 3'd2, 0, 5'b0, 2'd0, {nm, "_armed"});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    step(1, 0, 5'b0, 4'h0, 0, 3'd0, 0, 5'b0, 0, 0, 2'd0, "reset");
    step(1, 0, 5'b0, 4'h0, 0, 3'd0, 0, 5'b0, 0, 0, 2'd0, "reset2");
    // PIN entry while disarmed is ignored
    step(0, 0, 5'b0, 4'h7, 1, 3'd0, 0, 5'b0, 0, 0, 2'd0, "disarm_pin_ign");

    // 1: exit delay, arm_req inside EXIT ignored
    step(0, 1, 5'b0, 4'h0, 0, 3'd1, 0, 5'b0, 0, 0, 2'd0, "t1_arm");
    step(0, 1, 5'b0, 4'h0, 0, 3'd1, 0, 5'b0, 0, 0, 2'd0, "t1_rearm_ign");
    step(0, 0, 5'b11111, 4'h0, 0, 3'd1, 0, 5'b0, 0, 0, 2'd0, "t1_exit_motion");
    idle(13, 3'd1, 0, 5'b0, 2'd0, "t1_exit");
    idle(1, 3'd2, 0, 5'b0, 2'd0, "t1_armed");

    // 2: trip zone 2, entry expires into alarm, then disarm
    step(0, 0, 5'b00100, 4'h0, 0, 3'd3, 0, 5'b00100, 0, 0, 2'd0, "t2_trip");
    idle(7, 3'd3, 0, 5'b00100, 2'd0, "t2_entry");
    idle(1, 3'd4, 1, 5'b00100, 2'd0, "t2_alarm");
    idle(2, 3'd4, 1, 5'b00100, 2'd0, "t2_alarm_hold");
    step(0, 0, 5'b0, 4'h0, 1, 3'd0, 0, 5'b00100, 1, 0, 2'd0, "t2_disarm");
    idle(1, 3'd0, 0, 5'b00100, 2'd0, "t2_readback");

    // 3: correct PIN on the cycle the entry timer reaches zero wins
    arm_seq("t3");
    step(0, 0, 5'b00010, 4'h0, 0, 3'd3, 0, 5'b00010, 0, 0, 2'd0, "t3_trip");
    idle(7, 3'd3, 0, 5'b00010, 2'd0, "t3_entry");
    step(0, 0, 5'b0, 4'h0, 1, 3'd0, 0, 5'b00010, 1, 0, 2'd0, "t3_disarm_at_zero");
    idle(2, 3'd0, 0, 5'b00010, 2'd0, "t3_idle");

    // 4: three wrong PINs force lockout; PIN ignored there; expiry to alarm
    arm_seq("t4");
    step(0, 0, 5'b0, 4'h7, 1, 3'd2, 0, 5'b0, 0, 1, 2'd1, "t4_wrong1");
    step(0, 0, 5'b0, 4'h7, 1, 3'd2, 0, 5'b0, 0, 1, 2'd2, "t4_wrong2");
    step(0, 0, 5'b0, 4'h7, 1, 3'd5, 1, 5'b0, 0, 1, 2'd3, "t4_wrong3");
    step(0, 0, 5'b0, 4'h0, 1, 3'd5, 1, 5'b0, 0, 0, 2'd3, "t4_lock_pin_ign");
    idle(30, 3'd5, 1, 5'b0, 2'd3, "t4_lockout");
    idle(1, 3'd4, 1, 5'b0, 2'd0, "t4_lock_expire");
    step(0, 0, 5'b0, 4'h0, 1, 3'd0, 0, 5'b0, 1, 0, 2'd0, "t4_disarm");

`ifdef SEC_ZONE_BYPASS_EN
    // 5: bypassed zone 0 never trips
    bypass_mask = 5'b00001;
    arm_seq("t5");
    step(0, 0, 5'b00001, 4'h0, 0, 3'd2, 0, 5'b0, 0, 0, 2'd0, "t5_bypassed");
    step(0, 0, 5'b00011, 4'h0, 0, 3'd3, 0, 5'b00010, 0, 0, 2'd0, "t5_trip");
    step(0, 0, 5'b0, 4'h0, 1, 3'd0, 0, 5'b00010, 1, 0, 2'd0, "t5_disarm");
    bypass_mask = 5'b00000;
`endif

    // 6: reset in ALARM clears everything
    arm_seq("t6");
    step(0, 0, 5'b11000, 4'h0, 0, 3'd3, 0, 5'b11000, 0, 0, 2'd0, "t6_trip");
    idle(7, 3'd3, 0, 5'b11000, 2'd0, "t6_entry");
    idle(1, 3'd4, 1, 5'b11000, 2'd0, "t6_alarm");
    step(1, 0, 5'b0, 4'h0, 0, 3'd0, 0, 5'b0, 0, 0, 2'd0, "t6_rst");
    idle(1, 3'd0, 0, 5'b0, 2'd0, "t6_after_rst");

    repeat (3) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
